// File: rtl/scaled_clock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : scaled_clock_monitor
// Description : Synchronises a slow clock into the inclk domain. Emits rise/fall
//               ticks, measures the half-period and flags loss of the clock.
//               Optional frequency check enabled by macro SCLK_FREQ_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module scaled_clock_monitor #(
    parameter int          SYNC_STAGES = 2,
    parameter int          CNT_W       = 28,
    parameter logic [27:0] TIMEOUT     = 28'd25000,
    parameter logic [27:0] EXPECT_HALF = 28'd10001,
    parameter logic [27:0] TOL         = 28'd2
) (
    input  logic             inclk,
    input  logic             rstn,
    input  logic             ena,
    input  logic             sclk_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             lost,
    output logic             freq_err
);

    localparam int              c_W            = (CNT_W > 28) ? CNT_W : 28;
    localparam logic [c_W-1:0]  c_TIMEOUT_LAST = c_W'(TIMEOUT) - c_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_det_rise;
    logic                   r_det_fall;
    logic                   r_rise_tick;
    logic                   r_fall_tick;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_armed;
    logic [CNT_W-1:0]       r_half;
    logic                   r_valid;
    logic                   r_lost;

    logic                   w_level;
    logic                   w_edge;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_timeout;

    assign w_level    = r_sync[SYNC_STAGES-1];
    assign w_edge     = r_det_rise | r_det_fall;
    // Saturating increment doubles as the saturating capture value cnt+1.
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout  = (c_W'(r_cnt) == c_TIMEOUT_LAST);

    always_ff @(posedge inclk) begin
        if (!rstn) begin
            r_sync      <= '0;
            r_prev      <= 1'b0;
            r_det_rise  <= 1'b0;
            r_det_fall  <= 1'b0;
            r_rise_tick <= 1'b0;
            r_fall_tick <= 1'b0;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_half      <= '0;
            r_valid     <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            // Synchroniser and edge history run even when disabled.
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sclk_in};
            r_prev     <= w_level;
            r_det_rise <= w_level & ~r_prev;
            r_det_fall <= ~w_level & r_prev;
            if (!ena) begin
                r_rise_tick <= 1'b0;
                r_fall_tick <= 1'b0;
                r_cnt       <= '0;
                r_armed     <= 1'b0;
                r_valid     <= 1'b0;
                r_lost      <= 1'b0;
            end else begin
                r_rise_tick <= r_det_rise;
                r_fall_tick <= r_det_fall;
                if (w_edge) begin
                    r_cnt   <= '0;
                    r_lost  <= 1'b0;
                    r_armed <= 1'b1;
                    if (r_armed) begin
                        r_half  <= w_cnt_next;
                        r_valid <= 1'b1;
                    end
                end else begin
                    r_cnt <= w_cnt_next;
                    if (w_timeout) begin
                        r_lost  <= 1'b1;
                        r_valid <= 1'b0;
                        r_armed <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef SCLK_FREQ_CHECK_EN
    logic           r_freq_err;
    logic [c_W-1:0] w_cap;
    logic [c_W-1:0] w_exp;
    logic [c_W-1:0] w_diff;

    assign w_cap  = c_W'(w_cnt_next);
    assign w_exp  = c_W'(EXPECT_HALF);
    assign w_diff = (w_cap >= w_exp) ? (w_cap - w_exp) : (w_exp - w_cap);

    always_ff @(posedge inclk) begin
        if (!rstn) begin
            r_freq_err <= 1'b0;
        end else if (!ena) begin
            r_freq_err <= 1'b0;
        end else if (w_edge) begin
            if (r_armed) begin
                r_freq_err <= (w_diff > c_W'(TOL));
            end
        end else if (w_timeout) begin
            r_freq_err <= 1'b0;
        end
    end

    assign freq_err = r_freq_err;
`else
    logic w_unused_freq_cfg;
    assign w_unused_freq_cfg = ^{EXPECT_HALF, TOL};
    assign freq_err          = 1'b0;
`endif

    assign rise_tick    = r_rise_tick;
    assign fall_tick    = r_fall_tick;
    assign half_period  = r_half;
    assign period_valid = r_valid;
    assign lost         = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_scaled_clock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_scaled_clock_monitor
// Description : Directed bench with a tick scoreboard for scaled_clock_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scaled_clock_monitor;

    localparam int c_M       = 10001;
    localparam int c_TIMEOUT = 25000;
    localparam int c_LAT     = 3;

    logic        inclk = 1'b0;
    logic        rstn  = 1'b0;
    logic        ena   = 1'b0;
    logic        sclk_in = 1'b0;
    logic        rise_tick, fall_tick, period_valid, lost, freq_err;
    logic [27:0] half_period;

    logic        sclk2 = 1'b0;
    logic        rise2, fall2, valid2, lost2, ferr2;
    logic [3:0]  half2;

    scaled_clock_monitor u_dut (
        .inclk        (inclk),
        .rstn         (rstn),
        .ena          (ena),
        .sclk_in      (sclk_in),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .half_period  (half_period),
        .period_valid (period_valid),
        .lost         (lost),
        .freq_err     (freq_err)
    );

    scaled_clock_monitor #(.CNT_W(4), .TIMEOUT(28'd20)) u_sat (
        .inclk        (inclk),
        .rstn         (rstn),
        .ena          (ena),
        .sclk_in      (sclk2),
        .rise_tick    (rise2),
        .fall_tick    (fall2),
        .half_period  (half2),
        .period_valid (valid2),
        .lost         (lost2),
        .freq_err     (ferr2)
    );

    always #5 inclk = ~inclk;

    int cyc = 0;
    always @(posedge inclk) cyc++;

    int total = 0;
    int bad   = 0;
    int last_tick_cyc = 0;

    typedef struct {
        bit rise;
        int cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge inclk);
    endtask

    // Called on a negedge: the next posedge samples the new level.
    task automatic toggle_and_wait(input int n);
        exp_t e;
        sclk_in = ~sclk_in;
        e.rise  = sclk_in;
        e.cyc   = cyc + 1 + c_LAT;
        sb.push_back(e);
        step(n);
    endtask

    always @(negedge inclk) begin
        if (rise_tick || fall_tick) begin
            check("tick_exclusive", {31'd0, rise_tick & fall_tick}, 32'd0);
            if (sb.size() == 0) begin
                check("tick_unexpected", sb.size(), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("tick_kind", {31'd0, rise_tick}, {31'd0, mon_e.rise});
                check("tick_cycle", cyc, mon_e.cyc);
                last_tick_cyc = cyc;
            end
        end
    end

    initial begin
        rstn = 1'b0; ena = 1'b1; sclk_in = 1'b0; sclk2 = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            sclk_in = ~sclk_in;
            sclk2   = ~sclk2;
            step(1);
            check("rst_flags", {26'd0, rise_tick, fall_tick, period_valid, lost, freq_err, |half_period}, 32'd0);
            check("rst_sat_flags", {27'd0, rise2, fall2, valid2, lost2, |half2}, 32'd0);
        end
        sclk_in = 1'b0; sclk2 = 1'b0;
        step(2);
        rstn = 1'b1;
        step(2);
        check("idle_valid", {31'd0, period_valid}, 32'd0);

        // saturation: 18-cycle half period on a 4-bit counter
        sclk2 = 1'b1; step(18);
        check("sat_armed_valid", {31'd0, valid2}, 32'd0);
        sclk2 = 1'b0; step(18);
        check("sat_half", {28'd0, half2}, 32'd15);
        check("sat_valid", {31'd0, valid2}, 32'd1);
        check("sat_lost", {31'd0, lost2}, 32'd0);

        // square wave
        toggle_and_wait(c_M);
        check("arm_valid", {31'd0, period_valid}, 32'd0);
        check("arm_half", half_period, 32'd0);
        toggle_and_wait(c_M);
        check("half_1", half_period, c_M);
        check("valid_1", {31'd0, period_valid}, 32'd1);
        toggle_and_wait(c_M);
        check("half_2", half_period, c_M);
        check("valid_2", {31'd0, period_valid}, 32'd1);

        // loss of clock
        while (cyc < last_tick_cyc + c_TIMEOUT - 1) step(1);
        check("pre_lost", {31'd0, lost}, 32'd0);
        check("pre_lost_valid", {31'd0, period_valid}, 32'd1);
        step(1);
        check("lost_set", {31'd0, lost}, 32'd1);
        check("lost_valid", {31'd0, period_valid}, 32'd0);
        check("lost_half", half_period, c_M);

        // restart
        toggle_and_wait(7777);
        check("restart_lost", {31'd0, lost}, 32'd0);
        check("restart_valid", {31'd0, period_valid}, 32'd0);
        toggle_and_wait(100);
        check("restart_half", half_period, 32'd7777);
        check("restart_valid2", {31'd0, period_valid}, 32'd1);

        // enable drop with sclk_in high
        ena = 1'b0;
        step(1);
        check("dis_valid", {31'd0, period_valid}, 32'd0);
        check("dis_lost", {31'd0, lost}, 32'd0);
        check("dis_half", half_period, 32'd7777);
        check("dis_ferr", {31'd0, freq_err}, 32'd0);
        step(49);
        ena = 1'b1;
        step(20);
        check("reen_half", half_period, 32'd7777);
        check("reen_valid", {31'd0, period_valid}, 32'd0);
        toggle_and_wait(300);
        check("reen_arm_valid", {31'd0, period_valid}, 32'd0);
        toggle_and_wait(300);
        check("reen_half2", half_period, 32'd300);
        check("reen_valid2", {31'd0, period_valid}, 32'd1);

`ifdef SCLK_FREQ_CHECK_EN
        toggle_and_wait(10003);
        check("ferr_300", {31'd0, freq_err}, 32'd1);
        toggle_and_wait(10004);
        check("half_10003", half_period, 32'd10003);
        check("ferr_10003", {31'd0, freq_err}, 32'd0);
        toggle_and_wait(100);
        check("half_10004", half_period, 32'd10004);
        check("ferr_10004", {31'd0, freq_err}, 32'd1);
        ena = 1'b0;
        step(1);
        check("ferr_dis", {31'd0, freq_err}, 32'd0);
        ena = 1'b1;
`else
        check("ferr_tied", {31'd0, freq_err}, 32'd0);
`endif

        step(20);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
